// File: rtl/writeback_pc_pkg.sv
// rtl/writeback_pc_pkg.sv - shared types for the write-back / PC-generate stage
package writeback_pc_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_UART = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_sel_t;

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_UART = 1'b1
    } state_t;

    localparam int UART_BYTE_WIDTH = 8;

endpackage

// File: rtl/writeback_pc_unit_if.sv
// rtl/writeback_pc_unit_if.sv - instruction, UART receive and register-file bundle
interface writeback_pc_unit_if #(
    parameter int INST_MEM_WIDTH = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int JUMP_WIDTH     = 26
);
    logic                      valid_in;
    logic                      reg_write;
    logic [1:0]                wb_sel;
    logic [1:0]                pc_sel;
    logic                      branch_taken;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     register_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [JUMP_WIDTH-1:0]     inst_index;
    logic [INST_MEM_WIDTH-1:0] pc1;
    logic [INST_MEM_WIDTH-1:0] pc2;
    logic                      uart_rx_valid;
    logic [7:0]                uart_rx_data;
    logic                      uart_rx_ready;
    logic                      reg_write_out;
    logic [REG_ADDR_WIDTH-1:0] rd_out;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [INST_MEM_WIDTH-1:0] pc_next;
    logic                      pc_valid;
    logic                      stall;

    modport master (
        output valid_in, reg_write, wb_sel, pc_sel, branch_taken, read_data,
               alu_result, register_data, rd, inst_index, pc1, pc2,
               uart_rx_valid, uart_rx_data,
        input  uart_rx_ready, reg_write_out, rd_out, wb_data, pc_next,
               pc_valid, stall
    );

    modport slave (
        input  valid_in, reg_write, wb_sel, pc_sel, branch_taken, read_data,
               alu_result, register_data, rd, inst_index, pc1, pc2,
               uart_rx_valid, uart_rx_data,
        output uart_rx_ready, reg_write_out, rd_out, wb_data, pc_next,
               pc_valid, stall
    );

endinterface

// File: rtl/pc_select.sv
// rtl/pc_select.sv - combinational next-PC mux, shared with the fetch predictor
module pc_select
    import writeback_pc_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14,
    parameter int JUMP_WIDTH     = 26
) (
    input  pc_sel_t                   pc_sel,
    input  logic                      branch_taken,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic [INST_MEM_WIDTH-1:0] pc2,
    input  logic [JUMP_WIDTH-1:0]     inst_index,
    input  logic [INST_MEM_WIDTH-1:0] jr_target,
    output logic [INST_MEM_WIDTH-1:0] pc_next
);

    // Pick the fetch target; the jump immediate is truncated or zero-extended
    // to the PC width by the cast, so no arithmetic happens here.
    always_comb begin
        pc_next = pc1;
        case (pc_sel)
            PC_SEQ:    pc_next = pc1;
            PC_BRANCH: pc_next = branch_taken ? pc2 : pc1;
            PC_JUMP:   pc_next = INST_MEM_WIDTH'(inst_index);
            PC_JR:     pc_next = jr_target;
            default:   pc_next = pc1;
        endcase
    end

endmodule

// File: rtl/writeback_pc_unit.sv
// rtl/writeback_pc_unit.sv - write-back source select, next-PC generate and UART stall
module writeback_pc_unit
    import writeback_pc_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int JUMP_WIDTH     = 26
) (
    input  logic                clk,
    input  logic                reset,
    writeback_pc_unit_if.slave  bus
);

    state_t                    state;
    state_t                    state_nxt;
    wb_sel_t                   wb_sel;
    pc_sel_t                   pc_sel;
    logic                      uart_miss;
    logic                      rx_ready;
    logic                      emit_run;
    logic                      emit_wait;
    logic                      go_wait;
    logic [INST_MEM_WIDTH-1:0] pc_mux;
    logic [INST_MEM_WIDTH-1:0] jr_target;
    logic [DATA_WIDTH-1:0]     wb_mux;
    logic [DATA_WIDTH-1:0]     uart_ext;

    logic                      lat_reg_write;
    logic [REG_ADDR_WIDTH-1:0] lat_rd;
    logic [INST_MEM_WIDTH-1:0] lat_pc;

    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     wb_data_q;
    logic [INST_MEM_WIDTH-1:0] pc_next_q;
    logic                      pc_valid_q;
    logic                      stall_q;

    assign wb_sel    = wb_sel_t'(bus.wb_sel);
    assign pc_sel    = pc_sel_t'(bus.pc_sel);
    assign uart_miss = (wb_sel == WB_UART) && !bus.uart_rx_valid;
    assign jr_target = INST_MEM_WIDTH'(bus.register_data);
    assign uart_ext  = DATA_WIDTH'(bus.uart_rx_data);

    pc_select #(
        .INST_MEM_WIDTH (INST_MEM_WIDTH),
        .JUMP_WIDTH     (JUMP_WIDTH)
    ) u_pc_select (
        .pc_sel       (pc_sel),
        .branch_taken (bus.branch_taken),
        .pc1          (bus.pc1),
        .pc2          (bus.pc2),
        .inst_index   (bus.inst_index),
        .jr_target    (jr_target),
        .pc_next      (pc_mux)
    );

    // Write-back source mux; link and UART byte are zero-extended.
    always_comb begin
        wb_mux = bus.alu_result;
        case (wb_sel)
            WB_ALU:  wb_mux = bus.alu_result;
            WB_MEM:  wb_mux = bus.read_data;
            WB_LINK: wb_mux = DATA_WIDTH'(bus.pc1);
            WB_UART: wb_mux = uart_ext;
            default: wb_mux = bus.alu_result;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: park in WAIT_UART until the missing byte shows up.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (bus.valid_in && uart_miss) state_nxt = WAIT_UART;
            WAIT_UART: if (bus.uart_rx_valid)         state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    // FSM outputs: receive handshake and datapath strobes.
    always_comb begin
        rx_ready  = 1'b0;
        emit_run  = 1'b0;
        emit_wait = 1'b0;
        go_wait   = 1'b0;
        case (state)
            RUN: begin
                rx_ready = bus.valid_in && (wb_sel == WB_UART);
                emit_run = bus.valid_in && !uart_miss;
                go_wait  = bus.valid_in && uart_miss;
            end
            WAIT_UART: begin
                rx_ready  = 1'b1;
                emit_wait = bus.uart_rx_valid;
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

    // Ready is forced low during reset so no byte is taken by an abandoned instruction.
    assign bus.uart_rx_ready = rx_ready && !reset;

    // Registered write-back / PC outputs and the latch for a stalled UART read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_reg_write <= 1'b0;
            lat_rd        <= '0;
            lat_pc        <= '0;
            reg_write_q   <= 1'b0;
            rd_q          <= '0;
            wb_data_q     <= '0;
            pc_next_q     <= '0;
            pc_valid_q    <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            stall_q <= (state_nxt == WAIT_UART);
            if (go_wait) begin
                lat_reg_write <= bus.reg_write;
                lat_rd        <= bus.rd;
                lat_pc        <= pc_mux;
            end
            if (emit_run) begin
                reg_write_q <= bus.reg_write;
                rd_q        <= bus.rd;
                wb_data_q   <= wb_mux;
                pc_next_q   <= pc_mux;
                pc_valid_q  <= 1'b1;
            end else if (emit_wait) begin
                reg_write_q <= lat_reg_write;
                rd_q        <= lat_rd;
                wb_data_q   <= uart_ext;
                pc_next_q   <= lat_pc;
                pc_valid_q  <= 1'b1;
            end else begin
                reg_write_q <= 1'b0;
                pc_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.reg_write_out = reg_write_q;
    assign bus.rd_out        = rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.pc_next       = pc_next_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.stall         = stall_q;

endmodule

// File: tb/tb_writeback_pc_unit.sv
// tb/tb_writeback_pc_unit.sv - directed table-driven bench for writeback_pc_unit
module tb_writeback_pc_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    writeback_pc_unit_if #(.INST_MEM_WIDTH(14), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .JUMP_WIDTH(26)) bus ();
    writeback_pc_unit_if #(.INST_MEM_WIDTH(2),  .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .JUMP_WIDTH(26)) bus2 ();

    writeback_pc_unit #(.INST_MEM_WIDTH(14), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .JUMP_WIDTH(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    writeback_pc_unit #(.INST_MEM_WIDTH(2), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .JUMP_WIDTH(26)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic [1:0]  wb_sel;
        logic [1:0]  pc_sel;
        logic        br;
        logic        rw;
        logic [4:0]  rd;
        logic [13:0] pc1;
        logic        uv;
        logic [7:0]  ud;
        logic [31:0] exp_wb;
        logic [13:0] exp_pc;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rw"},    32'(bus.reg_write_out), 32'd0);
        chk({tag, "_rd"},    32'(bus.rd_out),        32'd0);
        chk({tag, "_wb"},    bus.wb_data,            32'd0);
        chk({tag, "_pc"},    32'(bus.pc_next),       32'd0);
        chk({tag, "_pv"},    32'(bus.pc_valid),      32'd0);
        chk({tag, "_rdy"},   32'(bus.uart_rx_ready), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall),         32'd0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.valid_in       = 1'b0;
        bus.reg_write      = 1'b0;
        bus.wb_sel         = 2'b00;
        bus.pc_sel         = 2'b00;
        bus.branch_taken   = 1'b0;
        bus.read_data      = 32'hffffffff;
        bus.alu_result     = 32'h11111111;
        bus.register_data  = 32'hFFFF1234;
        bus.rd             = 5'd0;
        bus.inst_index     = 26'h3FFFF20;
        bus.pc1            = 14'h0000;
        bus.pc2            = 14'h0100;
        bus.uart_rx_valid  = 1'b0;
        bus.uart_rx_data   = 8'h00;

        bus2.valid_in      = 1'b1;
        bus2.reg_write     = 1'b1;
        bus2.wb_sel        = 2'b10;
        bus2.pc_sel        = 2'b10;
        bus2.branch_taken  = 1'b0;
        bus2.read_data     = 32'h0;
        bus2.alu_result    = 32'h0;
        bus2.register_data = 32'h0;
        bus2.rd            = 5'd1;
        bus2.inst_index    = 26'h6;
        bus2.pc1           = 2'b11;
        bus2.pc2           = 2'b00;
        bus2.uart_rx_valid = 1'b0;
        bus2.uart_rx_data  = 8'h00;

        vecs[0] = '{2'b00, 2'b00, 1'b0, 1'b1, 5'd3, 14'h0002, 1'b0, 8'h00, 32'h11111111, 14'h0002, 1'b0};
        vecs[1] = '{2'b01, 2'b00, 1'b0, 1'b1, 5'd3, 14'h0002, 1'b0, 8'h00, 32'hffffffff, 14'h0002, 1'b0};
        vecs[2] = '{2'b10, 2'b00, 1'b0, 1'b1, 5'd3, 14'h0002, 1'b0, 8'h00, 32'h00000002, 14'h0002, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 1'b0, 1'b1, 5'd3, 14'h0010, 1'b1, 8'h55, 32'h00000055, 14'h0010, 1'b1};
        vecs[4] = '{2'b00, 2'b01, 1'b0, 1'b1, 5'd3, 14'h0010, 1'b0, 8'h00, 32'h11111111, 14'h0010, 1'b0};
        vecs[5] = '{2'b00, 2'b01, 1'b1, 1'b1, 5'd3, 14'h0010, 1'b0, 8'h00, 32'h11111111, 14'h0100, 1'b0};
        vecs[6] = '{2'b00, 2'b10, 1'b0, 1'b1, 5'd3, 14'h0010, 1'b0, 8'h00, 32'h11111111, 14'h3F20, 1'b0};
        vecs[7] = '{2'b00, 2'b11, 1'b0, 1'b1, 5'd3, 14'h0010, 1'b0, 8'h00, 32'h11111111, 14'h1234, 1'b0};
        vecs[8] = '{2'b01, 2'b00, 1'b0, 1'b0, 5'd7, 14'h0010, 1'b0, 8'h00, 32'hffffffff, 14'h0010, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        chk("reset_w2_wb", bus2.wb_data, 32'd0);
        reset = 1'b0;

        // Table-driven single-cycle instructions.
        for (int i = 0; i < 9; i++) begin
            bus.valid_in      = 1'b1;
            bus.wb_sel        = vecs[i].wb_sel;
            bus.pc_sel        = vecs[i].pc_sel;
            bus.branch_taken  = vecs[i].br;
            bus.reg_write     = vecs[i].rw;
            bus.rd            = vecs[i].rd;
            bus.pc1           = vecs[i].pc1;
            bus.uart_rx_valid = vecs[i].uv;
            bus.uart_rx_data  = vecs[i].ud;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(bus.uart_rx_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wb", i),    bus.wb_data,            vecs[i].exp_wb);
            chk($sformatf("v%0d_pc", i),    32'(bus.pc_next),       32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_rd", i),    32'(bus.rd_out),        32'(vecs[i].rd));
            chk($sformatf("v%0d_rw", i),    32'(bus.reg_write_out), 32'(vecs[i].rw));
            chk($sformatf("v%0d_pv", i),    32'(bus.pc_valid),      32'd1);
            chk($sformatf("v%0d_stall", i), 32'(bus.stall),         32'd0);
        end

        // Idle cycle: no write, pc_next held.
        bus.valid_in = 1'b0;
        bus.uart_rx_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rw", 32'(bus.reg_write_out), 32'd0);
        chk("idle_pv", 32'(bus.pc_valid),      32'd0);
        chk("idle_pc", 32'(bus.pc_next),       32'h0010);

        // UART wait: byte missing for 4 cycles, operands change meanwhile.
        bus.valid_in      = 1'b1;
        bus.wb_sel        = 2'b11;
        bus.pc_sel        = 2'b01;
        bus.branch_taken  = 1'b1;
        bus.reg_write     = 1'b1;
        bus.rd            = 5'd9;
        bus.pc1           = 14'h0020;
        bus.uart_rx_valid = 1'b0;
        #1;
        chk("uw_rdy0", 32'(bus.uart_rx_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.wb_sel = 2'b00;
                bus.pc_sel = 2'b00;
                bus.rd     = 5'd1;
                bus.pc1    = 14'h3333;
            end
            chk($sformatf("uw%0d_stall", k), 32'(bus.stall),         32'd1);
            chk($sformatf("uw%0d_rw", k),    32'(bus.reg_write_out), 32'd0);
            chk($sformatf("uw%0d_pv", k),    32'(bus.pc_valid),      32'd0);
            chk($sformatf("uw%0d_rdy", k),   32'(bus.uart_rx_ready), 32'd1);
        end
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        bus.valid_in      = 1'b0;
        bus.uart_rx_valid = 1'b0;
        chk("uw_done_wb",    bus.wb_data,            32'h000000A5);
        chk("uw_done_rd",    32'(bus.rd_out),        32'd9);
        chk("uw_done_rw",    32'(bus.reg_write_out), 32'd1);
        chk("uw_done_pc",    32'(bus.pc_next),       32'h0100);
        chk("uw_done_pv",    32'(bus.pc_valid),      32'd1);
        chk("uw_done_stall", 32'(bus.stall),         32'd0);
        @(posedge clk);
        #1;
        chk("uw_after_rw", 32'(bus.reg_write_out), 32'd0);
        chk("uw_after_pv", 32'(bus.pc_valid),      32'd0);

        // Reset while waiting for a byte.
        bus.valid_in      = 1'b1;
        bus.wb_sel        = 2'b11;
        bus.uart_rx_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rm_stall_pre", 32'(bus.stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rm");
        bus.valid_in      = 1'b0;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h3C;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_rel_rdy", 32'(bus.uart_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rm_post_rw",    32'(bus.reg_write_out), 32'd0);
        chk("rm_post_pv",    32'(bus.pc_valid),      32'd0);
        chk("rm_post_rdy",   32'(bus.uart_rx_ready), 32'd0);
        chk("rm_post_stall", 32'(bus.stall),         32'd0);
        bus.valid_in = 1'b1;
        #1;
        chk("rm_new_rdy", 32'(bus.uart_rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_in      = 1'b0;
        bus.uart_rx_valid = 1'b0;
        chk("rm_new_wb", bus.wb_data,       32'h0000003C);
        chk("rm_new_pv", 32'(bus.pc_valid), 32'd1);

        // Narrow-PC instance: link and jump at INST_MEM_WIDTH=2.
        chk("w2_wb", bus2.wb_data,            32'h00000003);
        chk("w2_pc", 32'(bus2.pc_next),       32'h2);
        chk("w2_pv", 32'(bus2.pc_valid),      32'd1);
        chk("w2_rw", 32'(bus2.reg_write_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_pc_unit.md
Name: writeback_pc_unit

Overview:
Final pipeline stage. It selects the register write-back source (ALU, memory, link PC or UART receive) and generates the next instruction-memory PC (sequential, branch, jump or register jump).
All outputs are registered. A UART-read instruction whose data is not yet available stalls the stage and the fetch PC through a two-state FSM with a valid/ready receive handshake.
Parametrised successor of the fixed-width write-buffer/PC-generate stage.

Parameters:
INST_MEM_WIDTH, 14, instruction-memory address width (PC width)
DATA_WIDTH, 32, register/data width; must be >= INST_MEM_WIDTH
REG_ADDR_WIDTH, 5, register-file index width
JUMP_WIDTH, 26, width of the jump immediate inst_index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  instruction present this cycle
reg_write  in  1  instruction writes a register
wb_sel  in  2  write-back source: 00 alu_result, 01 read_data, 10 pc1 (link), 11 UART
pc_sel  in  2  PC mode: 00 pc1, 01 branch, 10 jump, 11 register jump
branch_taken  in  1  branch condition result, used only when pc_sel=01
read_data  in  DATA_WIDTH  memory load data
alu_result  in  DATA_WIDTH  ALU result
register_data  in  DATA_WIDTH  register operand, used as target when pc_sel=11
rd  in  REG_ADDR_WIDTH  destination register
inst_index  in  JUMP_WIDTH  jump immediate
pc1  in  INST_MEM_WIDTH  PC+1 of this instruction
pc2  in  INST_MEM_WIDTH  branch target
uart_rx_valid  in  1  UART receive data available
uart_rx_data  in  8  received byte
uart_rx_ready  out  1  stage accepts the byte this cycle
reg_write_out  out  1  register-file write enable
rd_out  out  REG_ADDR_WIDTH  register-file write index
wb_data  out  DATA_WIDTH  register-file write data
pc_next  out  INST_MEM_WIDTH  next fetch PC
pc_valid  out  1  pc_next updated this cycle
stall  out  1  upstream must hold its instruction

Behaviour:
- Reset (asynchronous):
  - state=RUN.
  - reg_write_out, rd_out, wb_data, pc_next, pc_valid, uart_rx_ready, stall all drive 0.
- Accept: an instruction is accepted on a rising edge with valid_in=1 and stall=0. In RUN with no instruction accepted, reg_write_out=0 and pc_valid=0 for the next cycle; pc_next holds its value.
- Latency: exactly 1 cycle from accept to reg_write_out/wb_data/pc_next/pc_valid for wb_sel!=11, or for wb_sel=11 when the byte is taken the same cycle.
- Write-back width rules:
  - Link (wb_sel=10): pc1 zero-extended to DATA_WIDTH.
  - UART (wb_sel=11): byte zero-extended to DATA_WIDTH.
  - reg_write_out = reg_write of the accepted instruction.
- PC generation:
  - 00 -> pc1.
  - 01 -> pc2 if branch_taken, else pc1.
  - 10 -> inst_index[INST_MEM_WIDTH-1:0] (upper bits ignored when JUMP_WIDTH > INST_MEM_WIDTH, zero-extended otherwise).
  - 11 -> register_data[INST_MEM_WIDTH-1:0].
  - Wrap-around: pc1 = all-ones+1 is supplied upstream already wrapped; this stage does no arithmetic.
- FSM:
  - RUN: uart_rx_ready = valid_in & (wb_sel==11), combinational.
    - wb_sel=11 and uart_rx_valid=1 -> byte consumed, normal 1-cycle completion.
    - wb_sel=11 and uart_rx_valid=0 -> latch reg_write, rd, pc_sel result and pc1; go to WAIT_UART.
  - WAIT_UART:
    - stall=1; uart_rx_ready=1; reg_write_out=0; pc_valid=0.
    - On uart_rx_valid=1: capture the byte, emit the write and the latched pc_next on the next cycle (pc_valid=1), return to RUN.
  - Upstream inputs (valid_in, operands) are ignored while in WAIT_UART.
- stall is registered: high exactly while state=WAIT_UART, so it goes high the cycle after the missing byte is detected.
- Byte consumption: at most one byte per instruction; the byte is consumed only on the cycle uart_rx_valid & uart_rx_ready.
- Reset during WAIT_UART: abandon the instruction. No register write, no pc_valid, and no byte is consumed after reset.

Decomposition:
- Package writeback_pc_pkg:
  - enum wb_sel_t {WB_ALU, WB_MEM, WB_LINK, WB_UART}.
  - enum pc_sel_t {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR}.
  - enum state_t {RUN, WAIT_UART}.
- Sub-module pc_select: combinational PC mux, parametrised by INST_MEM_WIDTH and JUMP_WIDTH, reused by the fetch-stage predictor.

Test Plan:
- Reset mid-stream: assert reset with wb_sel=11 and no data -> all outputs 0 immediately. After release, with uart_rx_valid=1, uart_rx_ready stays 0 until a new instruction arrives.
- Write-back mux: alu_result=32'h11111111, read_data=32'hffffffff, pc1=14'h0002, wb_sel cycling 00/01/10 with rd=5'd3 -> wb_data = 11111111, ffffffff, 00000002 one cycle later, rd_out=3, reg_write_out=1.
- UART ready: wb_sel=11, uart_rx_valid=1, uart_rx_data=8'h55 -> uart_rx_ready=1 same cycle; next cycle wb_data=32'h00000055, stall never asserted.
- UART wait: wb_sel=11, uart_rx_valid=0 for 4 cycles, then 8'hA5 -> stall=1 for 4 cycles, reg_write_out=0 meanwhile, then a single write of 32'h000000A5 with pc_valid=1 and the latched pc_next.
- PC modes: pc1=14'h0010, pc2=14'h0100, inst_index=26'h3FFFF20, register_data=32'hFFFF1234:
  - 01 with branch_taken=0 -> 0010.
  - 01 with branch_taken=1 -> 0100.
  - 10 -> 3F20.
  - 11 -> 1234.
- Width generalisation: INST_MEM_WIDTH=2, pc1=2'b11, wb_sel=10 -> wb_data=32'h00000003; pc_sel=10 with inst_index=26'h6 -> pc_next=2'b10.
